// File: rtl/camera_config_pkg.sv
// -----------------------------------------------------------------------------
// camera_config_pkg
// Shared types and constants for the camera configuration sequencer.
//   state_t      : sequencer FSM states
//   END_MARKER   : table word that terminates the sequence
//   DELAY_PREFIX : upper byte marking an inline delay entry (low byte = ms)
//   cfg_entry_t  : one table word, {reg_addr, reg_data}
//   max3()       : elaboration helper used to size the shared cycle counter
// -----------------------------------------------------------------------------
package camera_config_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_POWERUP,
        ST_FETCH,
        ST_DECODE,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_DELAY,
        ST_NEXT,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam logic [15:0] END_MARKER   = 16'hFFFF;
    localparam logic [7:0]  DELAY_PREFIX = 8'hFE;

    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] reg_data;
    } cfg_entry_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/camera_config_if.sv
// -----------------------------------------------------------------------------
// camera_config_if
// Word handshake between the configuration sequencer and the SCCB/I2C write
// engine.
//   write_data_o : [15:8] register address, [7:0] register data
//   valid_o      : write_data_o is a request (sequencer -> engine)
//   i2c_ready_i  : engine idle, word accepted when valid_o && i2c_ready_i
//   i2c_done_i   : one-cycle pulse when the engine finishes a transfer
// Modports: master = sequencer side, slave = write engine side.
// -----------------------------------------------------------------------------
interface camera_config_if;

    logic [15:0] write_data_o;
    logic        valid_o;
    logic        i2c_ready_i;
    logic        i2c_done_i;

    modport master (
        output write_data_o,
        output valid_o,
        input  i2c_ready_i,
        input  i2c_done_i
    );

    modport slave (
        input  write_data_o,
        input  valid_o,
        output i2c_ready_i,
        output i2c_done_i
    );

endinterface

// File: rtl/camera_config_rom.sv
// -----------------------------------------------------------------------------
// camera_config_rom
// Fixed table of camera register writes with a registered (one-cycle) read.
// Entry formats: {addr, data} write, {8'hFE, ms} inline delay, 16'hFFFF end.
// SMOKE_TABLE = 1 selects a four-entry bring-up table (reset, 2 ms settle,
// clock prescaler, end) used for quick board bring-up; 0 selects the full
// sensor setup table. Both begin with the sensor soft reset and its delay.
// Ports:
//   clk_200_khz : clock
//   addr        : table index
//   data        : entry at addr, valid one cycle after addr is presented
// -----------------------------------------------------------------------------
module camera_config_rom
    import camera_config_pkg::*;
#(
    parameter int ROM_DEPTH   = 64,
    parameter int ADDR_W      = $clog2(ROM_DEPTH),
    parameter bit SMOKE_TABLE = 1'b0
) (
    input  logic              clk_200_khz,
    input  logic [ADDR_W-1:0] addr,
    output cfg_entry_t        data
);

    function automatic cfg_entry_t rom_entry(input int idx);
        cfg_entry_t e;
        e = END_MARKER;
        if (SMOKE_TABLE) begin
            case (idx)
                0:       e = 16'h1280;   // COM7: soft reset
                1:       e = 16'hFE02;   // settle after reset
                2:       e = 16'h1101;   // CLKRC: prescaler
                default: e = END_MARKER;
            endcase
        end else begin
            case (idx)
                0:       e = 16'h1280;   // COM7: soft reset
                1:       e = 16'hFE02;   // settle after reset
                2:       e = 16'h1101;   // CLKRC: prescaler
                3:       e = 16'h1204;   // COM7: RGB output
                4:       e = 16'h0C00;   // COM3
                5:       e = 16'h3E00;   // COM14: no PCLK scaling
                6:       e = 16'h8C00;   // RGB444 off
                7:       e = 16'h0400;   // COM1
                8:       e = 16'h40D0;   // COM15: RGB565 full range
                9:       e = 16'h3A04;   // TSLB
                10:      e = 16'h1418;   // COM9: AGC ceiling
                11:      e = 16'h4FB3;   // colour matrix 1..6
                12:      e = 16'h50B3;
                13:      e = 16'h5100;
                14:      e = 16'h523D;
                15:      e = 16'h53A7;
                16:      e = 16'h54E4;
                17:      e = 16'h589E;   // MTXS
                18:      e = 16'h3DC0;   // COM13: gamma, UV saturation
                19:      e = 16'h1714;   // HSTART
                20:      e = 16'h1802;   // HSTOP
                21:      e = 16'h3280;   // HREF
                22:      e = 16'h1903;   // VSTART
                23:      e = 16'h1A7B;   // VSTOP
                24:      e = 16'h030A;   // VREF
                25:      e = 16'h0F41;   // COM6
                26:      e = 16'h1E00;   // MVFP: no mirror/flip
                27:      e = 16'h330B;   // CHLF
                28:      e = 16'h3C78;   // COM12
                29:      e = 16'h6900;   // GFIX
                30:      e = 16'h7400;   // REG74
                31:      e = 16'hB084;   // undocumented colour fix
                32:      e = 16'hB10C;   // ABLC1
                33:      e = 16'hB20E;
                34:      e = 16'hB380;   // THL_ST
                default: e = END_MARKER;
            endcase
        end
        return e;
    endfunction

    cfg_entry_t table_mem [ROM_DEPTH];

    for (genvar gi = 0; gi < ROM_DEPTH; gi++) begin : g_rom
        assign table_mem[gi] = rom_entry(gi);
    end

    always_ff @(posedge clk_200_khz) begin
        data <= table_mem[addr];
    end

endmodule

// File: rtl/camera_config_sequencer.sv
// -----------------------------------------------------------------------------
// camera_config_sequencer
// After start, waits POWERUP_CYCLES, then walks the register table and hands
// each write word to the SCCB/I2C engine on a valid/ready/done handshake.
// Delay entries ({8'hFE, ms}) pause ms * MS_CYCLES cycles; 16'hFFFF or the
// last table slot ends the sequence. A transfer not finished within
// TIMEOUT_CYCLES of acceptance raises the sticky error flag.
// Build option: define CAMERA_CONFIG_RETRY_EN to re-issue a timed-out word up
// to MAX_RETRIES times before declaring an error.
// Ports:
//   clk_200_khz   : 200 kHz I2C-domain clock
//   reset_i       : asynchronous active-high reset
//   start_i       : begin sequence (level or pulse, ignored while busy)
//   bus           : camera_config_if.master (write_data_o/valid_o/ready/done)
//   busy_o        : sequence in progress
//   config_done_o : sticky, table completed
//   error_o       : sticky, a transfer timed out
// POWERUP_CYCLES and TIMEOUT_CYCLES must be at least 1.
// -----------------------------------------------------------------------------
module camera_config_sequencer
    import camera_config_pkg::*;
#(
    parameter int ROM_DEPTH      = 64,
    parameter int POWERUP_CYCLES = 60000,
    parameter int MS_CYCLES      = 200,
    parameter int TIMEOUT_CYCLES = 2048,
    parameter int MAX_RETRIES    = 3,
    parameter bit SMOKE_TABLE    = 1'b0
) (
    input  logic                   clk_200_khz,
    input  logic                   reset_i,
    input  logic                   start_i,
    camera_config_if.master        bus,
    output logic                   busy_o,
    output logic                   config_done_o,
    output logic                   error_o
);

    localparam int ADDR_W  = $clog2(ROM_DEPTH);
    // One counter serves power-up, delay and timeout; size for the longest.
    localparam int CNT_MAX = max3(POWERUP_CYCLES, 255 * MS_CYCLES, TIMEOUT_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] index_reg, index_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    cfg_entry_t        write_data_reg, write_data_next;
    logic              config_done_reg, config_done_next;
    logic              error_reg, error_next;
    cfg_entry_t        rom_data;

`ifdef CAMERA_CONFIG_RETRY_EN
    localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
    logic [RETRY_W-1:0] retry_reg, retry_next;
`endif

    camera_config_rom #(
        .ROM_DEPTH   (ROM_DEPTH),
        .ADDR_W      (ADDR_W),
        .SMOKE_TABLE (SMOKE_TABLE)
    ) u_rom (
        .clk_200_khz (clk_200_khz),
        .addr        (index_reg),
        .data        (rom_data)
    );

    always_ff @(posedge clk_200_khz or posedge reset_i) begin
        if (reset_i) begin
            state_reg       <= ST_IDLE;
            index_reg       <= '0;
            cnt_reg         <= '0;
            write_data_reg  <= '0;
            config_done_reg <= 1'b0;
            error_reg       <= 1'b0;
`ifdef CAMERA_CONFIG_RETRY_EN
            retry_reg       <= '0;
`endif
        end else begin
            state_reg       <= state_next;
            index_reg       <= index_next;
            cnt_reg         <= cnt_next;
            write_data_reg  <= write_data_next;
            config_done_reg <= config_done_next;
            error_reg       <= error_next;
`ifdef CAMERA_CONFIG_RETRY_EN
            retry_reg       <= retry_next;
`endif
        end
    end

    always_comb begin
        state_next       = state_reg;
        index_next       = index_reg;
        cnt_next         = cnt_reg;
        write_data_next  = write_data_reg;
        config_done_next = config_done_reg;
        error_next       = error_reg;
`ifdef CAMERA_CONFIG_RETRY_EN
        retry_next       = retry_reg;
`endif

        case (state_reg)
            ST_IDLE: begin
                if (start_i) begin
                    state_next       = ST_POWERUP;
                    index_next       = '0;
                    cnt_next         = '0;
                    config_done_next = 1'b0;
                    error_next       = 1'b0;
`ifdef CAMERA_CONFIG_RETRY_EN
                    retry_next       = '0;
`endif
                end
            end

            ST_POWERUP: begin
                if (cnt_reg == CNT_W'(POWERUP_CYCLES - 1)) begin
                    cnt_next   = '0;
                    state_next = ST_FETCH;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            // ROM address is index_reg; data appears at the next edge.
            ST_FETCH: state_next = ST_DECODE;

            ST_DECODE: begin
                if (rom_data == END_MARKER) begin
                    state_next = ST_DONE;
                end else if (rom_data.reg_addr == DELAY_PREFIX) begin
                    // A zero-length delay skips the DELAY state entirely so
                    // the entry costs only the NEXT/FETCH/DECODE overhead.
                    if (rom_data.reg_data == 8'h00) begin
                        state_next = ST_NEXT;
                    end else begin
                        cnt_next   = CNT_W'(32'(rom_data.reg_data) * MS_CYCLES);
                        state_next = ST_DELAY;
                    end
                end else begin
                    write_data_next = rom_data;
                    state_next      = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                if (bus.i2c_ready_i) begin
                    cnt_next   = '0;
                    state_next = ST_WAIT_DONE;
                end
            end

            ST_WAIT_DONE: begin
                if (bus.i2c_done_i) begin
                    state_next = ST_NEXT;
                end else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
`ifdef CAMERA_CONFIG_RETRY_EN
                    if (retry_reg == RETRY_W'(MAX_RETRIES)) begin
                        state_next = ST_ERROR;
                    end else begin
                        retry_next = retry_reg + 1'b1;
                        state_next = ST_ISSUE;
                    end
`else
                    state_next = ST_ERROR;
`endif
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            // Loaded with a non-zero count; leaves after exactly that many cycles.
            ST_DELAY: begin
                if (cnt_reg == CNT_W'(1)) begin
                    cnt_next   = '0;
                    state_next = ST_NEXT;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end

            ST_NEXT: begin
                cnt_next = '0;
`ifdef CAMERA_CONFIG_RETRY_EN
                retry_next = '0;
`endif
                // Last slot acts as an implicit end marker; index never wraps.
                if (index_reg == ADDR_W'(ROM_DEPTH - 1)) begin
                    state_next = ST_DONE;
                end else begin
                    index_next = index_reg + 1'b1;
                    state_next = ST_FETCH;
                end
            end

            ST_DONE: begin
                config_done_next = 1'b1;
                state_next       = ST_IDLE;
            end

            ST_ERROR: begin
                error_next = 1'b1;
                state_next = ST_IDLE;
            end

            default: state_next = ST_IDLE;
        endcase
    end

    // valid_o decodes the state register directly so that reset clears it
    // asynchronously together with the state.
    assign bus.valid_o      = (state_reg == ST_ISSUE);
    assign bus.write_data_o = write_data_reg;
    assign busy_o           = (state_reg != ST_IDLE);
    assign config_done_o    = config_done_reg;
    assign error_o          = error_reg;

endmodule

// File: tb/tb_camera_config_sequencer.sv
// -----------------------------------------------------------------------------
// tb_camera_config_sequencer
// Directed bench for camera_config_sequencer using the four-entry smoke table
// (0x1280, 0xFE02, 0x1101, 0xFFFF), POWERUP_CYCLES = 10, MS_CYCLES = 4.
// A stub write engine accepts words and, in its normal mode, pulses done 40
// cycles after acceptance. Build with CAMERA_CONFIG_RETRY_EN to cover the
// retry variant.
// -----------------------------------------------------------------------------
module tb_camera_config_sequencer;

    localparam int TIMEOUT = 2048;
`ifdef CAMERA_CONFIG_RETRY_EN
    localparam int EXP_RETRIES = 3;
`else
    localparam int EXP_RETRIES = 0;
`endif

    logic clk_200_khz;
    logic reset_i;
    logic start_i;
    logic busy_o;
    logic config_done_o;
    logic error_o;

    camera_config_if bus ();

    camera_config_sequencer #(
        .ROM_DEPTH      (64),
        .POWERUP_CYCLES (10),
        .MS_CYCLES      (4),
        .TIMEOUT_CYCLES (TIMEOUT),
        .MAX_RETRIES    (3),
        .SMOKE_TABLE    (1'b1)
    ) dut (
        .clk_200_khz   (clk_200_khz),
        .reset_i       (reset_i),
        .start_i       (start_i),
        .bus           (bus),
        .busy_o        (busy_o),
        .config_done_o (config_done_o),
        .error_o       (error_o)
    );

    initial begin
        clk_200_khz = 1'b0;
        forever #5 clk_200_khz = ~clk_200_khz;
    end

    int          total_cnt = 0;
    int          bad_cnt   = 0;
    int          stub_mode = 0;   // 0: respond after 40, 1: never done, 2: not ready
    logic [15:0] issued_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    // Stub engine: sees a handshake at the negedge before the accepting edge.
    initial begin : stub_engine
        bus.i2c_ready_i = 1'b0;
        bus.i2c_done_i  = 1'b0;
        forever begin
            @(negedge clk_200_khz);
            bus.i2c_ready_i = (stub_mode != 2);
            if (bus.valid_o && bus.i2c_ready_i && !reset_i) begin
                issued_q.push_back(bus.write_data_o);
                @(posedge clk_200_khz);
                if (stub_mode == 0) begin
                    #1 bus.i2c_ready_i = 1'b0;
                    repeat (39) @(posedge clk_200_khz);
                    #1 bus.i2c_done_i = 1'b1;
                    @(posedge clk_200_khz);
                    #1 bus.i2c_done_i = 1'b0;
                end
            end
        end
    end

    // Start pulse spanning one rising edge; returns the number of rising
    // edges, starting with the one that samples start_i, until valid_o.
    task automatic start_and_time(output int n);
        @(negedge clk_200_khz);
        start_i = 1'b1;
        n = 0;
        while (n < 200) begin
            @(posedge clk_200_khz);
            n++;
            @(negedge clk_200_khz);
            start_i = 1'b0;
            if (bus.valid_o) break;
        end
    endtask

    task automatic wait_finish(output int n);
        n = 0;
        while (n < 300 && !config_done_o && !error_o) begin
            @(negedge clk_200_khz);
            n++;
        end
    endtask

    initial begin : main
        int lat;
        int gap;
        int n;
        int vcount;
        bit held_ok;

        reset_i = 1'b1;
        start_i = 1'b0;
        repeat (3) @(negedge clk_200_khz);
        chk("rst_write_data", bus.write_data_o, 16'h0000);
        chk("rst_valid", bus.valid_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_config_done", config_done_o, 1'b0);
        chk("rst_error", error_o, 1'b0);
        reset_i = 1'b0;
        repeat (3) @(negedge clk_200_khz);
        chk("idle_no_start_busy", busy_o, 1'b0);

        // ---- full sequence with a responding engine ----
        stub_mode = 0;
        issued_q.delete();
        start_and_time(lat);
        chk("first_valid_lat", lat, 13);
        chk("first_word", bus.write_data_o, 16'h1280);
        held_ok = 1'b1;
        n = 0;
        while (n < 200) begin
            @(negedge clk_200_khz);
            n++;
            start_i = (n == 10);   // restart attempt while busy
            if (bus.i2c_done_i) break;
            if (bus.write_data_o !== 16'h1280 || bus.valid_o) held_ok = 1'b0;
        end
        start_i = 1'b0;
        chk("word_held_until_done", {31'd0, held_ok}, 1);
        gap = 0;
        while (gap < 100) begin
            @(negedge clk_200_khz);
            if (bus.valid_o) break;
            gap++;
        end
        // NEXT/FETCH/DECODE of the delay entry + 8 delay cycles +
        // NEXT/FETCH/DECODE of the following write entry.
        chk("delay_gap", gap, 3 + 8 + 3);
        chk("second_word", bus.write_data_o, 16'h1101);
        wait_finish(n);
        chk("seq_config_done", config_done_o, 1'b1);
        chk("seq_busy", busy_o, 1'b0);
        chk("seq_error", error_o, 1'b0);
        chk("seq_word_count", issued_q.size(), 2);
        if (issued_q.size() >= 2) begin
            chk("seq_q0", issued_q[0], 16'h1280);
            chk("seq_q1", issued_q[1], 16'h1101);
        end

        // ---- engine never finishes: timeout (and retries if enabled) ----
        repeat (5) @(negedge clk_200_khz);
        stub_mode = 1;
        issued_q.delete();
        start_and_time(lat);
        chk("to_first_valid_lat", lat, 13);
        chk("to_config_done_cleared", config_done_o, 1'b0);
        n = 0;
        vcount = 0;
        while (n < 10000) begin
            @(posedge clk_200_khz);
            @(negedge clk_200_khz);
            n++;
            if (bus.valid_o) vcount++;
            if (error_o) break;
        end
        // Each retry costs TIMEOUT cycles waiting plus one ISSUE cycle; the
        // final attempt adds TIMEOUT cycles, the ERROR cycle and the
        // accepting edge.
        chk("to_error_latency", n, EXP_RETRIES * (TIMEOUT + 1) + TIMEOUT + 2);
        chk("to_reissue_valids", vcount, EXP_RETRIES);
        chk("to_issue_count", issued_q.size(), 1 + EXP_RETRIES);
        if (issued_q.size() > 0) begin
            chk("to_last_word", issued_q[issued_q.size() - 1], 16'h1280);
        end
        chk("to_error", error_o, 1'b1);
        chk("to_busy", busy_o, 1'b0);
        chk("to_config_done", config_done_o, 1'b0);

        // ---- reset while waiting for done ----
        repeat (5) @(negedge clk_200_khz);
        stub_mode = 0;
        issued_q.delete();
        start_and_time(lat);
        chk("rw_first_valid_lat", lat, 13);
        chk("rw_error_cleared", error_o, 1'b0);
        repeat (5) @(negedge clk_200_khz);
        chk("rw_word_before_reset", bus.write_data_o, 16'h1280);
        #2 reset_i = 1'b1;
        #1;
        chk("rw_write_data", bus.write_data_o, 16'h0000);
        chk("rw_valid", bus.valid_o, 1'b0);
        chk("rw_busy", busy_o, 1'b0);
        repeat (3) @(negedge clk_200_khz);
        reset_i = 1'b0;
        repeat (60) @(negedge clk_200_khz);   // stale done pulse lands in IDLE
        chk("rw_idle_busy", busy_o, 1'b0);
        chk("rw_idle_config_done", config_done_o, 1'b0);
        chk("rw_word_count", issued_q.size(), 1);

        // ---- reset while a word is presented but not accepted ----
        stub_mode = 2;
        issued_q.delete();
        start_and_time(lat);
        chk("ri_first_valid_lat", lat, 13);
        repeat (3) @(negedge clk_200_khz);
        chk("ri_valid_held", bus.valid_o, 1'b1);
        chk("ri_word_held", bus.write_data_o, 16'h1280);
        #2 reset_i = 1'b1;
        #1;
        chk("ri_valid_async", bus.valid_o, 1'b0);
        chk("ri_busy_async", busy_o, 1'b0);
        repeat (2) @(negedge clk_200_khz);
        reset_i = 1'b0;
        stub_mode = 0;
        repeat (2) @(negedge clk_200_khz);
        start_and_time(lat);
        chk("rs_first_valid_lat", lat, 13);
        chk("rs_first_word", bus.write_data_o, 16'h1280);
        wait_finish(n);
        chk("rs_config_done", config_done_o, 1'b1);
        chk("rs_word_count", issued_q.size(), 2);
        if (issued_q.size() >= 2) begin
            chk("rs_q1", issued_q[1], 16'h1101);
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
